// File: rtl/ccore_pkg.sv
// ccore_pkg: shared types and reset constants for the clocked handshake pipe.
//   in_state_e  - upstream (SENDIN/ACKOUT) boundary FSM states
//   out_state_e - downstream (SENDOUT/ACKIN) boundary FSM states
//   RST_*       - values taken by the corresponding registers under RESET
package ccore_pkg;

    typedef enum logic [0:0] {
        IIDLE = 1'b0,
        IACK  = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        OIDLE = 2'd0,
        OREQ  = 2'd1,
        OWAIT = 2'd2
    } out_state_e;

    localparam logic RST_FULL = 1'b0;
    localparam logic RST_CP   = 1'b0;
    localparam logic RST_ACK  = 1'b0;
    localparam logic RST_REQ  = 1'b0;

endpackage

// File: rtl/ccore_stage.sv
// ccore_stage: one token slot of the pipe.
//   CLK, RESET - system clock, synchronous active-high reset
//   en_i       - global enable (LOPEN); low holds FULL/DATA and forces CP to 0
//   load_i     - slot takes data_i this cycle
//   clear_i    - slot's token leaves this cycle (ignored when load_i is high)
//   data_i     - incoming token
//   full_o     - slot holds a token
//   data_o     - held token
//   cp_o       - one-cycle pulse in the cycle after a load
module ccore_stage
    import ccore_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o,
    output logic             cp_o
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic             cp_q;

    // A load wins over a clear so a slot that empties and refills in the
    // same cycle stays full.
    always_comb begin
        full_d = load_i | (full_q & ~clear_i);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            full_q <= RST_FULL;
            data_q <= '0;
            cp_q   <= RST_CP;
        end else if (en_i) begin
            full_q <= full_d;
            if (load_i) begin
                data_q <= data_i;
            end
            cp_q <= load_i;
        end else begin
            cp_q <= RST_CP;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign cp_o   = cp_q;

endmodule

// File: rtl/ccore_pipe.sv
// ccore_pipe: clocked chain of DEPTH token stages with four-phase
// return-to-zero handshakes at both boundaries.
//   CLK, RESET   - system clock, synchronous active-high reset (beats LOPEN)
//   LOPEN        - global enable; low freezes every register, CP reads 0
//   G[k]         - guard; high blocks stage k from loading
//   SENDIN       - upstream request, DATAIN stable while high
//   DATAIN       - upstream token
//   ACKOUT       - upstream acknowledge
//   SENDOUT      - downstream request, DATAOUT valid while high
//   DATAOUT      - token in the last stage
//   ACKIN        - downstream acknowledge
//   CP[k]        - one-cycle pulse after stage k loads
//   dbg_*_o      - input FSM state, output FSM state, stage FULL flags
//
// Handshake: both boundaries are four-phase. A request rises, the
// acknowledge rises, the request falls, the acknowledge falls; a new
// request may only rise after the acknowledge has fallen. The token is
// transferred on the request/acknowledge high-high phase.
module ccore_pipe
    import ccore_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOPEN,
    input  logic [DEPTH-1:0] G,
    input  logic             SENDIN,
    input  logic [WIDTH-1:0] DATAIN,
    output logic             ACKOUT,
    output logic             SENDOUT,
    output logic [WIDTH-1:0] DATAOUT,
    input  logic             ACKIN,
    output logic [DEPTH-1:0] CP,
    output logic             dbg_istate_o,
    output logic [1:0]       dbg_ostate_o,
    output logic [DEPTH-1:0] dbg_full_o
);

    in_state_e        istate_q;
    out_state_e       ostate_q;
    logic             ackout_q;
    logic             sendout_q;

    logic [DEPTH-1:0] full_w;
    logic [DEPTH-1:0] load_w;
    logic [DEPTH-1:0] clear_w;
    logic [DEPTH-1:0] cp_w;
    logic [WIDTH-1:0] data_w [DEPTH];

    // Every move decision looks only at registered FULL flags, so a bubble
    // crosses exactly one stage per cycle.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] src;

        if (k == 0) begin : g_head
            // Capturing only from IIDLE keeps a held SENDIN from loading twice.
            assign load_w[k] = (istate_q == IIDLE) & SENDIN & ~full_w[k] & ~G[k];
            assign src       = DATAIN;
        end else begin : g_body
            assign load_w[k] = full_w[k-1] & ~full_w[k] & ~G[k];
            assign src       = data_w[k-1];
        end

        if (k == DEPTH - 1) begin : g_tail
            assign clear_w[k] = (ostate_q == OREQ) & ACKIN;
        end else begin : g_link
            assign clear_w[k] = load_w[k+1];
        end

        ccore_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .CLK     (CLK),
            .RESET   (RESET),
            .en_i    (LOPEN),
            .load_i  (load_w[k]),
            .clear_i (clear_w[k]),
            .data_i  (src),
            .full_o  (full_w[k]),
            .data_o  (data_w[k]),
            .cp_o    (cp_w[k])
        );
    end

    // Upstream boundary FSM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            istate_q <= IIDLE;
            ackout_q <= RST_ACK;
        end else if (LOPEN) begin
            case (istate_q)
                IIDLE: begin
                    if (load_w[0]) begin
                        istate_q <= IACK;
                        ackout_q <= 1'b1;
                    end
                end
                IACK: begin
                    if (!SENDIN) begin
                        istate_q <= IIDLE;
                        ackout_q <= 1'b0;
                    end
                end
                default: begin
                    istate_q <= IIDLE;
                    ackout_q <= 1'b0;
                end
            endcase
        end
    end

    // Downstream boundary FSM. An ACKIN already high in OIDLE is a protocol
    // violation; the request is held back until ACKIN returns low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ostate_q  <= OIDLE;
            sendout_q <= RST_REQ;
        end else if (LOPEN) begin
            case (ostate_q)
                OIDLE: begin
                    if (full_w[DEPTH-1] && !ACKIN) begin
                        ostate_q  <= OREQ;
                        sendout_q <= 1'b1;
                    end
                end
                OREQ: begin
                    if (ACKIN) begin
                        ostate_q  <= OWAIT;
                        sendout_q <= 1'b0;
                    end
                end
                OWAIT: begin
                    if (!ACKIN) begin
                        ostate_q <= OIDLE;
                    end
                end
                default: begin
                    ostate_q  <= OIDLE;
                    sendout_q <= 1'b0;
                end
            endcase
        end
    end

    assign ACKOUT       = ackout_q;
    assign SENDOUT      = sendout_q;
    assign DATAOUT      = data_w[DEPTH-1];
    assign CP           = cp_w;
    assign dbg_istate_o = istate_q;
    assign dbg_ostate_o = ostate_q;
    assign dbg_full_o   = full_w;

endmodule

// File: tb/tb_ccore_pipe.sv
module tb_ccore_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             LOPEN;
    logic [DEPTH-1:0] G;
    logic             SENDIN;
    logic [WIDTH-1:0] DATAIN;
    logic             ACKOUT;
    logic             SENDOUT;
    logic [WIDTH-1:0] DATAOUT;
    logic             ACKIN;
    logic [DEPTH-1:0] CP;
    logic             dbg_istate;
    logic [1:0]       dbg_ostate;
    logic [DEPTH-1:0] dbg_full;

    ccore_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .LOPEN        (LOPEN),
        .G            (G),
        .SENDIN       (SENDIN),
        .DATAIN       (DATAIN),
        .ACKOUT       (ACKOUT),
        .SENDOUT      (SENDOUT),
        .DATAOUT      (DATAOUT),
        .ACKIN        (ACKIN),
        .CP           (CP),
        .dbg_istate_o (dbg_istate),
        .dbg_ostate_o (dbg_ostate),
        .dbg_full_o   (dbg_full)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] up_q[$];
    int   checks;
    int   errors;
    int   accepted;
    int   delivered;
    int   ds_state;
    int   ds_delay;
    bit   ds_en;
    logic ackout_prev;

    typedef struct {
        logic             sendin;
        logic [WIDTH-1:0] datain;
        logic             ackin;
        logic             exp_ackout;
        logic             exp_sendout;
        logic [DEPTH-1:0] exp_cp;
        logic [WIDTH-1:0] exp_dataout;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic s, logic [WIDTH-1:0] d, logic a,
                                logic ao, logic so, logic [DEPTH-1:0] c,
                                logic [WIDTH-1:0] dout);
        vec_t v;
        v.sendin = s; v.datain = d; v.ackin = a;
        v.exp_ackout = ao; v.exp_sendout = so; v.exp_cp = c; v.exp_dataout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- driver / monitor engine ----------------
    // One clock: observe acceptances (model: every ACKOUT rise takes the
    // token on DATAIN and pulses CP[0]), then run the upstream four-phase
    // driver and, if enabled, the downstream responder.
    task automatic step();
        tick();
        chk("cp0_vs_accept", 32'(CP[0]), 32'(ACKOUT & ~ackout_prev));
        if (ACKOUT && !ackout_prev) begin
            exp_q.push_back(DATAIN);
            accepted++;
            chk("occupancy", 32'(exp_q.size() <= DEPTH), 32'd1);
        end
        ackout_prev = ACKOUT;

        if (SENDIN && ACKOUT) begin
            SENDIN = 1'b0;
        end else if (!SENDIN && !ACKOUT && up_q.size() > 0) begin
            DATAIN = up_q.pop_front();
            SENDIN = 1'b1;
        end

        if (ds_en) begin
            case (ds_state)
                0: if (SENDOUT) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out: got %h expected no token", DATAOUT);
                    end else begin
                        chk("out_order", 32'(DATAOUT), 32'(exp_q.pop_front()));
                    end
                    delivered++;
                    ds_delay = $urandom_range(0, 3);
                    ds_state = 1;
                end
                1: if (ds_delay == 0) begin
                    ACKIN    = 1'b1;
                    ds_state = 2;
                end else begin
                    ds_delay--;
                end
                default: if (!SENDOUT) begin
                    ACKIN    = 1'b0;
                    ds_state = 0;
                end
            endcase
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; LOPEN = 1'b1; SENDIN = 1'b0; ACKIN = 1'b0;
        G = '0; DATAIN = '0;
        tick();
        tick();
        RESET = 1'b0;
        exp_q.delete();
        up_q.delete();
        accepted = 0; delivered = 0; ds_state = 0; ds_en = 1'b0;
        ackout_prev = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cp2_seen;
        int lat;
        checks = 0; errors = 0;

        // Reset with a request already pending: nothing may be captured.
        RESET = 1'b1; LOPEN = 1'b1; SENDIN = 1'b1; DATAIN = 8'hC3;
        ACKIN = 1'b0; G = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("reset%0d_outs", i), 32'({ACKOUT, SENDOUT, CP, DATAOUT}), 32'd0);
            chk($sformatf("reset%0d_full", i), 32'(dbg_full), 32'd0);
        end
        SENDIN = 1'b0;
        RESET  = 1'b0;
        tick();
        chk("post_reset_outs", 32'({ACKOUT, SENDOUT, CP, DATAOUT, dbg_full}), 32'd0);

        // Table: single token, then a held SENDIN plus early ACKIN.
        vecs[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h00);
        vecs[1]  = mk(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 4'b0010, 8'h00);
        vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h00);
        vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b1000, 8'hA5);
        vecs[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'b0000, 8'hA5);
        vecs[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0000, 8'hA5);
        vecs[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 8'hA5);
        vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 8'hA5);
        vecs[8]  = mk(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 4'b0001, 8'hA5);
        vecs[9]  = mk(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 4'b0010, 8'hA5);
        vecs[10] = mk(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 4'b0100, 8'hA5);
        vecs[11] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'b1000, 8'h5A);
        vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h5A);
        vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h5A);
        vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h5A);
        vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h5A);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            SENDIN = vecs[i].sendin;
            DATAIN = vecs[i].datain;
            ACKIN  = vecs[i].ackin;
            tick();
            chk($sformatf("vec%0d_ackout", i),  32'(ACKOUT),  32'(vecs[i].exp_ackout));
            chk($sformatf("vec%0d_sendout", i), 32'(SENDOUT), 32'(vecs[i].exp_sendout));
            chk($sformatf("vec%0d_cp", i),      32'(CP),      32'(vecs[i].exp_cp));
            chk($sformatf("vec%0d_dataout", i), 32'(DATAOUT), 32'(vecs[i].exp_dataout));
        end
        chk("vec_end_full", 32'(dbg_full), 32'd0);

        // Fill with ACKIN held low: exactly DEPTH tokens fit.
        do_reset();
        for (int i = 1; i <= 6; i++) up_q.push_back(8'(i));
        for (int n = 0; n < 30; n++) step();
        chk("fill_accepted", accepted, 4);
        chk("fill_stall_ackout", 32'(ACKOUT), 32'd0);
        chk("fill_sendin_pending", 32'(SENDIN), 32'd1);
        chk("fill_full", 32'(dbg_full), 32'hF);
        chk("fill_sendout", 32'(SENDOUT), 32'd1);
        // One drain: the freed slot walks back one stage per cycle.
        chk("drain_first", 32'(DATAOUT), 32'(exp_q.pop_front()));
        delivered++;
        ACKIN = 1'b1;
        step();
        chk("bubble0", 32'({SENDOUT, dbg_full}), 32'({1'b0, 4'b0111}));
        ACKIN = 1'b0;
        step();
        chk("bubble1", 32'(dbg_full), 32'(4'b1011));
        step();
        chk("bubble2", 32'(dbg_full), 32'(4'b1101));
        step();
        chk("bubble3", 32'({ACKOUT, dbg_full}), 32'({1'b0, 4'b1110}));
        step();
        chk("bubble4", 32'({ACKOUT, CP[0], dbg_full}), 32'({1'b1, 1'b1, 4'b1111}));
        ds_en = 1'b1; ds_state = 0;
        for (int n = 0; n < 200 && delivered < 6; n++) step();
        chk("drain_delivered", delivered, 6);
        chk("drain_accepted", accepted, 6);
        chk("drain_left", exp_q.size(), 0);

        // Guard on stage 2.
        do_reset();
        ds_en = 1'b1;
        G = 4'b0100;
        up_q.push_back(8'hAA);
        up_q.push_back(8'hBB);
        cp2_seen = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (CP[2]) cp2_seen++;
        end
        chk("guard_cp2", cp2_seen, 0);
        chk("guard_full", 32'(dbg_full), 32'(4'b0011));
        chk("guard_accepted", accepted, 2);
        G = '0;
        step();
        chk("guard_release_cp2", 32'(CP[2]), 32'd1);
        for (int n = 0; n < 100 && delivered < 2; n++) step();
        chk("guard_delivered", delivered, 2);
        chk("guard_left", exp_q.size(), 0);

        // Freeze mid-transfer while the boundary inputs wiggle.
        do_reset();
        up_q.push_back(8'h11);
        up_q.push_back(8'h22);
        for (int n = 0; n < 30; n++) step();
        chk("prefreeze", 32'({SENDOUT, ACKOUT, DATAOUT, dbg_full}),
            32'({1'b1, 1'b0, 8'h11, 4'b1100}));
        LOPEN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ACKIN  = ~ACKIN;
            SENDIN = 1'b1;
            DATAIN = 8'h99;
            G      = 4'($urandom);
            tick();
            chk($sformatf("freeze%0d_cp", i), 32'(CP), 32'd0);
            chk($sformatf("freeze%0d_state", i), 32'({SENDOUT, ACKOUT, DATAOUT, dbg_full}),
                32'({1'b1, 1'b0, 8'h11, 4'b1100}));
        end
        ACKIN = 1'b0; SENDIN = 1'b0; G = '0;
        LOPEN = 1'b1;
        ds_en = 1'b1;
        for (int n = 0; n < 100 && delivered < 2; n++) step();
        chk("freeze_delivered", delivered, 2);
        chk("freeze_accepted", accepted, 2);
        chk("freeze_left", exp_q.size(), 0);

        // Reset with three tokens resident and SENDOUT high.
        do_reset();
        up_q.push_back(8'h31);
        up_q.push_back(8'h32);
        up_q.push_back(8'h33);
        for (int n = 0; n < 30; n++) step();
        chk("premid_reset", 32'({SENDOUT, dbg_full}), 32'({1'b1, 4'b1110}));
        RESET = 1'b1;
        tick();
        chk("mid_reset_outs", 32'({ACKOUT, SENDOUT, CP, DATAOUT, dbg_full}), 32'd0);
        RESET = 1'b0;
        SENDIN = 1'b1;
        DATAIN = 8'h3C;
        tick();
        chk("lat_ack", 32'({ACKOUT, CP[0]}), 32'(2'b11));
        SENDIN = 1'b0;
        lat = 0;
        while (!SENDOUT && lat < 20) begin
            tick();
            lat++;
        end
        chk("lat_sendout", lat, DEPTH);
        chk("lat_dataout", 32'(DATAOUT), 32'h3C);
        ACKIN = 1'b1;
        tick();
        chk("lat_sendout_low", 32'(SENDOUT), 32'd0);
        ACKIN = 1'b0;
        tick();
        tick();
        chk("lat_idle", 32'({dbg_full, dbg_ostate}), 32'd0);

        // Randomized traffic with random guards and freezes.
        do_reset();
        ds_en = 1'b1;
        for (int i = 0; i < 40; i++) up_q.push_back(8'($urandom_range(0, 255)));
        for (int n = 0; n < 6000 && delivered < 40; n++) begin
            G     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            LOPEN = ($urandom_range(0, 7) != 0);
            step();
        end
        LOPEN = 1'b1;
        G = '0;
        chk("rand_delivered", delivered, 40);
        chk("rand_accepted", accepted, 40);
        chk("rand_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccore_pipe.md
# ccore_pipe

- Clocked, parametrised successor to the self-timed C-element handshake core.
- Emulates a chain of DEPTH handshake stages, each carrying a WIDTH-bit data token, with per-stage guard inputs and a global freeze (LOPEN).
- Upstream and downstream boundaries use four-phase return-to-zero SENDIN/ACKOUT and SENDOUT/ACKIN handshakes, so the block drops into existing token-ring fabrics on the single system clock.

## Interface
Parameters:
- WIDTH, 8, data token width (≥1)
- DEPTH, 4, number of stages (≥1)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset; overrides LOPEN
- LOPEN  in  1  global enable; low freezes all state
- G  in  DEPTH  per-stage guard; G[k]=1 blocks stage k from loading
- SENDIN  in  1  upstream request
- DATAIN  in  WIDTH  upstream token, stable while SENDIN=1
- ACKOUT  out  1  upstream acknowledge
- SENDOUT  out  1  downstream request
- DATAOUT  out  WIDTH  downstream token (= stage DEPTH-1 data)
- ACKIN  in  1  downstream acknowledge
- CP  out  DEPTH  one-cycle load pulse per stage

## Operation
- Per-stage state: FULL[k] plus DATA[k].
- All decisions use start-of-cycle values (registered, no combinational stage-to-stage ripple).
- Input FSM (IIDLE, IACK):
  - IIDLE→IACK when SENDIN & ~FULL[0] & ~G[0]: load DATA[0]←DATAIN, FULL[0]←1, ACKOUT←1.
  - IACK→IIDLE when ~SENDIN: ACKOUT←0.
  - No capture in IACK, so a held SENDIN never double-loads.
- Internal move k-1→k (k≥1) when FULL[k-1] & ~FULL[k] & ~G[k]:
  - DATA[k]←DATA[k-1], FULL[k]←1.
  - FULL[k-1]←0 unless stage k-1 also loads in the same cycle.
  - A bubble travels backward one stage per cycle.
- Output FSM (OIDLE, OREQ, OWAIT):
  - OIDLE→OREQ when FULL[D-1] & ~ACKIN: SENDOUT←1.
  - OREQ→OWAIT when ACKIN: SENDOUT←0, FULL[D-1]←0.
  - OWAIT→OIDLE when ~ACKIN.
  - Stage D-1 cannot reload until the cycle after FULL[D-1] clears.
- CP[k]=1 for exactly the cycle after stage k loads. CP is registered.
- LOPEN=0: FSMs, FULL, DATA and SENDOUT/ACKOUT hold; CP forced 0; handshake inputs ignored.
- RESET: FULL=0, DATA=0, FSMs idle, ACKOUT=0, SENDOUT=0, CP=0, DATAOUT=0.
- RESET mid-transfer drops all tokens. Upstream and downstream must restart their handshakes.

## Timing
- Reset values: every output 0.
- Empty pipe, G=0, SENDIN sampled high at edge e0:
  - ACKOUT=1 and CP[0]=1 after e0.
  - FULL[k] set after edge ek.
  - SENDOUT=1 after edge eD.
  - Latency from ACKOUT↑ to SENDOUT↑ is DEPTH cycles (DEPTH=1: 1 cycle).
- Sustained throughput: one token per max(input loop, output loop) cycles.
  - Input loop ≥2 cycles.
  - Output loop ≥3 cycles with immediate ACKIN.
- Full pipe: after one output drain, the freed slot propagates to stage 0 in D-1 cycles. ACKOUT can then rise on the next edge.
- Simultaneous SENDIN↑ and G[0]=1: no load until the first edge where G[0]=0.
- ACKIN high while in OIDLE (protocol violation): SENDOUT is not raised; the FSM waits for ACKIN low.

## Structure
- Package ccore_pkg:
  - input FSM state enum (IIDLE, IACK)
  - output FSM state enum (OIDLE, OREQ, OWAIT)
  - reset constants
- Sub-module ccore_stage:
  - one FULL/DATA register pair with load and clear enables, and the CP register
  - instantiated DEPTH times via generate
- Top level holds the boundary FSMs and the move-enable logic.

## Test plan
- Reset: assert RESET 2 cycles with SENDIN=1, LOPEN=1 -> all outputs 0; no capture during reset.
- Single token, WIDTH=8, DEPTH=4, DATAIN=0xA5 -> ACKOUT↑ 1 edge after SENDIN sampled; CP pulses 0,1,2,3 on consecutive cycles; SENDOUT↑ 4 cycles after ACKOUT↑ with DATAOUT=0xA5; handshake completes, pipe empty.
- Fill and drain: send 0x01..0x06 with ACKIN held 0 -> exactly 4 accepted and ACKOUT stalls on the 5th; then cycle ACKIN -> outputs 0x01..0x06 in order, no loss or duplication.
- Guard: hold G[2]=1 while 2 tokens enter -> tokens stop in stages 0–1, CP[2] stays 0; release G[2] -> CP[2] pulses next cycle and flow resumes.
- Freeze: drop LOPEN for 5 cycles mid-transfer while toggling ACKIN -> CP=0, state and outputs unchanged; operation resumes exactly where it stopped.
- Reset mid-flight: RESET with 3 tokens resident and SENDOUT=1 -> next cycle SENDOUT=0, ACKOUT=0, all FULL clear; a subsequent token 0x3C passes with normal latency.
